// File: rtl/sigma_board_pkg.sv
// Shared types for the board reset controller: sequencer states, reset-cause
// encodings and a counter-width helper.
package sigma_board_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STAGGER   = 2'd1,
    RUN       = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR       = 2'd0,
    CAUSE_LOCK_LOSS = 2'd1,
    CAUSE_SW        = 2'd2
  } cause_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: synchroniser chain followed by a stable-count debouncer that
// produces a clean level and a single-cycle rising pulse.
module btn_debounce
  import sigma_board_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int              CW       = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   btn_sync;
  logic                   differ;

  assign btn_sync = sync_reg[SYNC_STAGES-1];
  assign differ   = btn_sync ^ level_reg;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
      rise_reg <= 1'b0;
      if (!differ) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= btn_sync;
        rise_reg  <= btn_sync;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign btn_level = level_reg;
  assign btn_rise  = rise_reg;

endmodule

// File: rtl/board_rst_ctrl.sv
// Board reset sequencer: waits for PLL lock, releases reset domains one by one,
// records the last reset cause, and debounces the board buttons.
module board_rst_ctrl
  import sigma_board_pkg::*;
#(
  parameter int NUM_DOMAINS     = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int RELEASE_DELAY   = 16,
  parameter int NUM_BTN         = 1,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   pll_locked_i,
  input  logic                   sw_rst_req_i,
  input  logic [NUM_BTN-1:0]     btn_i,
  output logic [NUM_DOMAINS-1:0] domain_arst_o,
  output logic                   ready_o,
  output logic [1:0]             rst_cause_o,
  output logic [NUM_BTN-1:0]     btn_o,
  output logic [NUM_BTN-1:0]     btn_pulse_o
);

  localparam int            CNT_MAX_I = RELEASE_DELAY * NUM_DOMAINS;
  localparam int            CW        = cnt_w(CNT_MAX_I);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CNT_MAX_I);

  logic [SYNC_STAGES-1:0] lock_sync_reg;
  logic                   lock_sync;
  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next, cnt_inc;
  logic [NUM_DOMAINS-1:0] domain_reg, domain_next, release_hit;
  logic                   ready_reg, ready_next;
  cause_t                 cause_reg, cause_next;

  assign lock_sync = lock_sync_reg[SYNC_STAGES-1];
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_release
    localparam logic [CW-1:0] THR = CW'(RELEASE_DELAY * (gi + 1));
    assign release_hit[gi] = (cnt_inc >= THR);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lock_sync_reg <= '0;
      state_reg     <= WAIT_LOCK;
      cnt_reg       <= '0;
      domain_reg    <= '1;
      ready_reg     <= 1'b0;
      cause_reg     <= CAUSE_POR;
    end else begin
      lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked_i};
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      domain_reg    <= domain_next;
      ready_reg     <= ready_next;
      cause_reg     <= cause_next;
    end
  end

  // Lock loss is checked before the software request so it wins the cause.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    domain_next = domain_reg;
    ready_next  = ready_reg;
    cause_next  = cause_reg;
    case (state_reg)
      WAIT_LOCK: begin
        domain_next = '1;
        ready_next  = 1'b0;
        if (lock_sync) begin
          state_next = STAGGER;
          cnt_next   = '0;
        end
      end
      STAGGER, RUN: begin
        if (!lock_sync) begin
          state_next  = WAIT_LOCK;
          domain_next = '1;
          ready_next  = 1'b0;
          cause_next  = CAUSE_LOCK_LOSS;
        end else if (state_reg == RUN && sw_rst_req_i) begin
          state_next  = WAIT_LOCK;
          domain_next = '1;
          ready_next  = 1'b0;
          cause_next  = CAUSE_SW;
        end else begin
          cnt_next    = cnt_inc;
          domain_next = domain_reg & ~release_hit;
          if (release_hit[NUM_DOMAINS-1]) begin
            state_next = RUN;
            ready_next = 1'b1;
          end
        end
      end
      default: begin
        state_next  = WAIT_LOCK;
        domain_next = '1;
        ready_next  = 1'b0;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk      (clk_i),
      .rst_n    (arst_n_i),
      .btn_raw  (btn_i[gi]),
      .btn_level(btn_o[gi]),
      .btn_rise (btn_pulse_o[gi])
    );
  end

  assign domain_arst_o = domain_reg;
  assign ready_o       = ready_reg;
  assign rst_cause_o   = cause_reg;

endmodule

// File: tb/tb_board_rst_ctrl.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle;
// a negedge monitor pops an entry whenever the outputs change and compares.
module tb_board_rst_ctrl;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       pll_locked = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [0:0] btn = 1'b0;
  logic [2:0] dom;
  logic       ready;
  logic [1:0] cause;
  logic [0:0] btn_lvl;
  logic [0:0] btn_pls;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int         cyc;
    bit         chk_cyc;
    logic [2:0] dom;
    logic       rdy;
    logic [1:0] cause;
    logic       btn;
    logic       pulse;
    string      tag;
  } ev_t;

  ev_t exp_q[$];

  board_rst_ctrl #(
    .NUM_DOMAINS    (3),
    .SYNC_STAGES    (2),
    .RELEASE_DELAY  (4),
    .NUM_BTN        (1),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .pll_locked_i (pll_locked),
    .sw_rst_req_i (sw_rst_req),
    .btn_i        (btn),
    .domain_arst_o(dom),
    .ready_o      (ready),
    .rst_cause_o  (cause),
    .btn_o        (btn_lvl),
    .btn_pulse_o  (btn_pls)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push(input string tag, input int at, input logic [2:0] d, input logic r,
                      input logic [1:0] c, input logic b, input logic p);
    ev_t e;
    e.cyc = at; e.chk_cyc = (at >= 0); e.dom = d; e.rdy = r;
    e.cause = c; e.btn = b; e.pulse = p; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every change of the output bundle consumes one expectation.
  initial begin
    logic [7:0] snap, last;
    bit first;
    ev_t e;
    first = 1'b1;
    last = '0;
    #3;
    forever begin
      @(negedge clk);
      snap = {dom, ready, cause, btn_lvl, btn_pls};
      if (first || snap !== last) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d got dom=%b rdy=%b cause=%0d btn=%b pulse=%b, expected no change",
                   cyc, dom, ready, cause, btn_lvl, btn_pls);
        end else begin
          e = exp_q.pop_front();
          if ((e.chk_cyc && e.cyc != cyc) || snap !== {e.dom, e.rdy, e.cause, e.btn, e.pulse})
            $display("FAIL %s got cyc=%0d dom=%b rdy=%b cause=%0d btn=%b pulse=%b, expected cyc=%0d dom=%b rdy=%b cause=%0d btn=%b pulse=%b",
                     e.tag, cyc, dom, ready, cause, btn_lvl, btn_pls,
                     e.cyc, e.dom, e.rdy, e.cause, e.btn, e.pulse);
          else
            passed++;
        end
      end
      last = snap;
      first = 1'b0;
    end
  end

  initial begin
    int b;
    #1;
    push("reset", -1, 3'b111, 0, 0, 0, 0);
    arst_n = 1'b0;
    wait_neg(2);

    // Power-up: STAGGER on 3rd edge, releases 4/8/12 later.
    arst_n = 1'b1; b = cyc;
    $display("txn power_up base=%0d", b);
    push("pu_d0",  b + 7,  3'b110, 0, 0, 0, 0);
    push("pu_d1",  b + 11, 3'b100, 0, 0, 0, 0);
    push("pu_run", b + 15, 3'b000, 1, 0, 0, 0);
    wait_neg(20);

    // Lock loss in RUN for 10 cycles.
    pll_locked = 1'b0; b = cyc;
    $display("txn lock_loss_run base=%0d", b);
    push("ll_assert", b + 3, 3'b111, 0, 1, 0, 0);
    wait_neg(10);
    pll_locked = 1'b1; b = cyc;
    push("ll_d0",  b + 7,  3'b110, 0, 1, 0, 0);
    push("ll_d1",  b + 11, 3'b100, 0, 1, 0, 0);
    push("ll_run", b + 15, 3'b000, 1, 1, 0, 0);
    wait_neg(20);

    // Software reset in RUN, then an ignored request during STAGGER.
    sw_rst_req = 1'b1; b = cyc;
    $display("txn sw_reset_run base=%0d", b);
    push("sw_assert", b + 1,  3'b111, 0, 2, 0, 0);
    push("sw_d0",     b + 6,  3'b110, 0, 2, 0, 0);
    push("sw_d1",     b + 10, 3'b100, 0, 2, 0, 0);
    push("sw_run",    b + 14, 3'b000, 1, 2, 0, 0);
    wait_neg(1);
    sw_rst_req = 1'b0;
    wait_neg(2);
    $display("txn sw_reset_in_stagger base=%0d", cyc);
    sw_rst_req = 1'b1;
    wait_neg(1);
    sw_rst_req = 1'b0;
    wait_neg(20);

    // Lock loss and software request seen on the same edge: lock loss wins.
    pll_locked = 1'b0; b = cyc;
    $display("txn lock_and_sw base=%0d", b);
    wait_neg(2);
    sw_rst_req = 1'b1;
    wait_neg(1);
    sw_rst_req = 1'b0;
    push("both_assert", b + 3, 3'b111, 0, 1, 0, 0);
    wait_neg(7);
    pll_locked = 1'b1; b = cyc;
    push("both_d0",  b + 7,  3'b110, 0, 1, 0, 0);
    push("both_d1",  b + 11, 3'b100, 0, 1, 0, 0);
    push("both_run", b + 15, 3'b000, 1, 1, 0, 0);
    wait_neg(20);

    // Lock loss after domain 0 released: domains 1/2 must never drop.
    sw_rst_req = 1'b1; b = cyc;
    $display("txn lock_loss_stagger base=%0d", b);
    wait_neg(1);
    sw_rst_req = 1'b0;
    push("mid_sw", b + 1, 3'b111, 0, 2, 0, 0);
    push("mid_d0", b + 6, 3'b110, 0, 2, 0, 0);
    wait_neg(5);
    pll_locked = 1'b0;
    push("mid_ll", b + 9, 3'b111, 0, 1, 0, 0);
    wait_neg(6);
    pll_locked = 1'b1; b = cyc;
    push("mid_d0b", b + 7,  3'b110, 0, 1, 0, 0);
    push("mid_d1b", b + 11, 3'b100, 0, 1, 0, 0);
    push("mid_run", b + 15, 3'b000, 1, 1, 0, 0);
    wait_neg(20);

    // Bouncing button, then held high.
    $display("txn button_bounce base=%0d", cyc);
    for (int k = 0; k < 10; k++) begin
      btn = (k % 2 == 0) ? 1'b1 : 1'b0;
      wait_neg(3);
    end
    btn = 1'b1; b = cyc;
    push("btn_rise",  b + 10, 3'b000, 1, 1, 1, 1);
    push("btn_pulse", b + 11, 3'b000, 1, 1, 1, 0);
    wait_neg(20);

    // Asynchronous reset mid-STAGGER: visible before the next clock edge.
    sw_rst_req = 1'b1; b = cyc;
    $display("txn arst_mid_stagger base=%0d", b);
    wait_neg(1);
    sw_rst_req = 1'b0;
    push("ar_sw", b + 1, 3'b111, 0, 2, 1, 0);
    push("ar_d0", b + 6, 3'b110, 0, 2, 1, 0);
    wait_neg(7);
    @(posedge clk);
    #1;
    push("ar_rst", cyc, 3'b111, 0, 0, 0, 0);
    arst_n = 1'b0;
    wait_neg(2);
    arst_n = 1'b1; b = cyc;
    push("ar_d0b",  b + 7,  3'b110, 0, 0, 0, 0);
    push("ar_btn",  b + 10, 3'b110, 0, 0, 1, 1);
    push("ar_d1b",  b + 11, 3'b100, 0, 0, 1, 0);
    push("ar_run",  b + 15, 3'b000, 1, 0, 1, 0);
    wait_neg(20);

    checks++;
    if (exp_q.size() != 0)
      $display("FAIL leftover_events got %0d pending, expected 0 (next %s)", exp_q.size(), exp_q[0].tag);
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
